// File: rtl/approx_mul_pkg.sv
// Shared types, sizes and the l=4 approximate-multiplier compensation function
// for the round-robin shared multiplier.
package approx_mul_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  // One operation as captured at accept time.
  typedef struct packed {
    logic [7:0]     x;
    logic [7:0]     y;
    logic [IDW-1:0] id;
    logic           approx;
  } mul_op_t;

  // Compensation for the truncated low nibble of x (l=4).
  // pp_i = y & {8{x[i]}}, i=0..3, contributes pp_i << i to the exact product.
  // Columns of weight 2^8..2^10 are kept exactly (6 terms). Column 2^7
  // (pp3[4], pp2[5], pp1[6], pp0[7]) is folded by an approximate 4:2 step:
  // each AND pair becomes a carry at 2^8 and any lone bit becomes one 2^7.
  // Everything below 2^7 is dropped. Result is in units of 2 (caller shifts
  // left by 1) so the 9-term sum fits in 11 bits; max is 1728.
  function automatic logic [10:0] approx_l4_comp(input logic [3:0] xl,
                                                 input logic [7:0] y);
    logic [7:0]  pp [4];
    logic        ca, cb, cc;
    logic [10:0] s;
    for (int i = 0; i < 4; i++) pp[i] = y & {8{xl[i]}};
    ca = pp[3][4] & pp[2][5];
    cb = pp[1][6] & pp[0][7];
    cc = (pp[3][4] ^ pp[2][5]) | (pp[1][6] ^ pp[0][7]);
    s  = (11'(pp[3][7]) << 9)
       + (11'(pp[3][6]) << 8) + (11'(pp[2][7]) << 8)
       + (11'(pp[3][5]) << 7) + (11'(pp[2][6]) << 7) + (11'(pp[1][7]) << 7)
       + (11'(ca) << 7) + (11'(cb) << 7)
       + (11'(cc) << 6);
    return s;
  endfunction

endpackage

// File: rtl/approx_mul_rr_sched_if.sv
// Requester-side and result-side handshake bundle for the shared multiplier.
// Requester i owns lane i of req_valid/req_x/req_y/req_ready.
interface approx_mul_rr_sched_if
  import approx_mul_pkg::*;
();
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0][7:0] req_x;
  logic [NREQ-1:0][7:0] req_y;
  logic                 approx_en;
  logic                 res_valid;
  logic                 res_ready;
  logic [15:0]          res_z;
  logic [IDW-1:0]       res_id;
  logic                 res_approx;

  modport master (
    output req_valid, req_x, req_y, approx_en, res_ready,
    input  req_ready, res_valid, res_z, res_id, res_approx
  );

  modport slave (
    input  req_valid, req_x, req_y, approx_en, res_ready,
    output req_ready, res_valid, res_z, res_id, res_approx
  );
endinterface

// File: rtl/approx_mul_rr_sched_core.sv
// Combinational 8x8 unsigned multiplier core: exact product, or the l=4
// approximation (high nibble exact, low nibble replaced by compensation).
module mul_core_8x8
  import approx_mul_pkg::*;
(
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic        approx,
  output logic [15:0] z
);
  logic [15:0] exact_z;
  logic [15:0] hi_z;
  logic [15:0] comp_z;

  assign exact_z = 16'(x) * 16'(y);
  assign hi_z    = (16'(y) * 16'(x[7:4])) << 4;
  // Compensation comes back in units of 2; max total stays below 2^16.
  assign comp_z  = {4'b0, approx_l4_comp(x[3:0], y), 1'b0};
  assign z       = approx ? (hi_z + comp_z) : exact_z;
endmodule

// File: rtl/approx_mul_rr_sched.sv
// Round-robin scheduler in front of one shared 8x8 multiplier.
// Stage 1: arbitrate and register the winning operands.
// Stage 2: multiply and register the tagged result.
module approx_mul_rr_sched
  import approx_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  approx_mul_rr_sched_if.slave bus
);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic [NREQ-1:0] gnt;
  logic [IDW:0]   idx;
  logic [IDW:0]   gnt_inc;
  logic [IDW:0]   rr_next;

  logic           s1_valid;
  mul_op_t        s1_op;
  mul_op_t        op_in;
  logic           s1_free;
  logic           s2_free;
  logic           accept;

  logic [15:0]    core_z;
  logic           res_valid;
  logic [15:0]    res_z;
  logic [IDW-1:0] res_id;
  logic           res_approx;

  // Pipeline advance conditions: stage 2 drains on res_ready, stage 1 on stage 2.
  assign s2_free = !res_valid | bus.res_ready;
  assign s1_free = !s1_valid | s2_free;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!gnt_any && bus.req_valid[idx[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[IDW-1:0];
      end
    end
  end

  // One-hot grant vector from the winning index.
  always_comb begin
    gnt         = '0;
    gnt[gnt_id] = gnt_any;
  end

  // Ready is held low in reset so nothing is taken while the pipe is cleared.
  assign bus.req_ready = (rst || !s1_free) ? '0 : gnt;
  assign accept        = gnt_any & s1_free & !rst;

  assign gnt_inc = {1'b0, gnt_id} + {{IDW{1'b0}}, 1'b1};
  assign rr_next = (gnt_inc == NREQ_W) ? '0 : gnt_inc;

  // Only the granted lane is muxed, so idle lanes never reach the datapath.
  assign op_in.x      = bus.req_x[gnt_id];
  assign op_in.y      = bus.req_y[gnt_id];
  assign op_in.id     = gnt_id;
  assign op_in.approx = bus.approx_en;

  // Stage 1: capture the accepted operation and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      rr_ptr   <= '0;
    end else begin
      if (s1_free) s1_valid <= accept;
      if (accept) begin
        s1_op  <= op_in;
        rr_ptr <= rr_next[IDW-1:0];
      end
    end
  end

  mul_core_8x8 u_core (
    .x      (s1_op.x),
    .y      (s1_op.y),
    .approx (s1_op.approx),
    .z      (core_z)
  );

  // Stage 2: register the product; held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_z      <= '0;
      res_id     <= '0;
      res_approx <= 1'b0;
    end else if (s2_free) begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_z      <= core_z;
        res_id     <= s1_op.id;
        res_approx <= s1_op.approx;
      end
    end
  end

  assign bus.res_valid  = res_valid;
  assign bus.res_z      = res_z;
  assign bus.res_id     = res_id;
  assign bus.res_approx = res_approx;
endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// Directed and randomised checks for the round-robin shared multiplier.
module tb_approx_mul_rr_sched;
  import approx_mul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_mul_rr_sched_if bus();

  approx_mul_rr_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_res = 0;
  logic [16:0] expq [NREQ][$];
  logic [NREQ-1:0] acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Golden product: column-by-column walk over the low-nibble partial-product bits.
  function automatic logic [15:0] gold(input logic [7:0] x, input logic [7:0] y, input logic ap);
    int acc_v;
    logic [3:0] b7;
    if (!ap) return 16'(int'(x) * int'(y));
    acc_v = int'(y) * int'(x[7:4]) * 16;
    b7 = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        if (x[i] && y[j]) begin
          if (i + j >= 8) acc_v += (1 << (i + j));
          else if (i + j == 7) b7[i] = 1'b1;
        end
    acc_v += (b7[3] && b7[2]) ? 256 : 0;
    acc_v += (b7[1] && b7[0]) ? 256 : 0;
    acc_v += ((b7[3] ^ b7[2]) || (b7[1] ^ b7[0])) ? 128 : 0;
    return 16'(acc_v);
  endfunction

  // Single isolated op on one lane; checks 2-cycle latency and per-op approx capture.
  task automatic send_one(input int lane, input logic [7:0] x, input logic [7:0] y,
                          input logic ap, input logic [15:0] expz, input string tag);
    bus.req_valid = '0;
    bus.req_valid[lane] = 1'b1;
    bus.req_x[lane] = x;
    bus.req_y[lane] = y;
    bus.approx_en = ap;
    bus.res_ready = 1'b1;
    smp();
    chk({tag, "_ready"}, 32'(bus.req_ready), 1 << lane);
    nxt();
    bus.req_valid = '0;
    bus.approx_en = ~ap;
    smp();
    chk({tag, "_lat1_vld"}, 32'(bus.res_valid), 0);
    nxt();
    smp();
    chk({tag, "_vld"}, 32'(bus.res_valid), 1);
    chk({tag, "_z"}, 32'(bus.res_z), 32'(expz));
    chk({tag, "_id"}, 32'(bus.res_id), lane);
    chk({tag, "_apx"}, 32'(bus.res_approx), 32'(ap));
    nxt();
  endtask

  // Pop and compare a result if one transfers this cycle.
  task automatic handle_res();
    logic [16:0] e;
    int id;
    if (bus.res_valid && bus.res_ready) begin
      id = int'(bus.res_id);
      if (expq[id].size() == 0) begin
        chk("rnd_unexpected_res", 32'(expq[id].size()), 1);
      end else begin
        e = expq[id].pop_front();
        chk("rnd_z", 32'(bus.res_z), 32'(e[15:0]));
        chk("rnd_apx", 32'(bus.res_approx), 32'(e[16]));
        n_res++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.approx_en = 1'b0;
    bus.res_ready = 1'b0;
    nxt();
    nxt();
    smp();
    // Reset state, with all requesters asking
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_z", 32'(bus.res_z), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    chk("rst_res_approx", 32'(bus.res_approx), 0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 0);
    nxt();
    rst = 1'b0;
    bus.req_valid = '0;

    // Exact and approximate single ops
    send_one(0, 8'hFF, 8'hFF, 1'b0, 16'd65025, "exact_ff_ff");
    send_one(1, 8'h0F, 8'hFF, 1'b1, 16'd3328,  "apx_0f_ff");
    send_one(2, 8'h10, 8'h03, 1'b1, 16'd48,    "apx_10_03");
    send_one(3, 8'hFF, 8'hFF, 1'b1, 16'd64528, "apx_ff_ff");
    send_one(0, 8'h0F, 8'hFF, 1'b0, 16'd3825,  "exact_0f_ff");

    // Fairness: fresh pointer, all lanes active, 8 ops each
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[i] = 8'(i + 1);
      bus.req_y[i] = 8'(10 + i);
    end
    bus.approx_en = 1'b0;
    bus.res_ready = 1'b1;
    bus.req_valid = '1;
    for (int k = 0; k < 34; k++) begin
      smp();
      if (k < 32) chk("fair_gnt", 32'(bus.req_ready), 1 << (k % 4));
      if (k >= 2) begin
        chk("fair_vld", 32'(bus.res_valid), 1);
        chk("fair_id", 32'(bus.res_id), (k - 2) % 4);
        chk("fair_z", 32'(bus.res_z), (((k - 2) % 4) + 1) * (10 + ((k - 2) % 4)));
      end
      nxt();
      if (k == 31) bus.req_valid = '0;
    end

    // Backpressure: consumer stalls, two ops enter, then everything holds
    bus.req_x[0] = 8'h0F; bus.req_y[0] = 8'hFF;
    bus.req_x[1] = 8'h10; bus.req_y[1] = 8'h03;
    bus.req_x[2] = 8'h55; bus.req_y[2] = 8'hAA;
    bus.req_x[3] = 8'h77; bus.req_y[3] = 8'h11;
    bus.approx_en = 1'b1;
    bus.res_ready = 1'b0;
    bus.req_valid = '1;
    smp();
    chk("bp_gnt0", 32'(bus.req_ready), 32'h1);
    nxt();
    smp();
    chk("bp_gnt1", 32'(bus.req_ready), 32'h2);
    chk("bp_vld_early", 32'(bus.res_valid), 0);
    nxt();
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("bp_hold_vld", 32'(bus.res_valid), 1);
      chk("bp_hold_z", 32'(bus.res_z), 3328);
      chk("bp_hold_id", 32'(bus.res_id), 0);
      chk("bp_hold_apx", 32'(bus.res_approx), 1);
      chk("bp_stall_ready", 32'(bus.req_ready), 0);
      nxt();
    end
    bus.res_ready = 1'b1;
    bus.req_valid = '0;
    smp();
    chk("bp_rel_a_z", 32'(bus.res_z), 3328);
    chk("bp_rel_a_vld", 32'(bus.res_valid), 1);
    nxt();
    smp();
    chk("bp_rel_b_z", 32'(bus.res_z), 48);
    chk("bp_rel_b_id", 32'(bus.res_id), 1);
    chk("bp_rel_b_vld", 32'(bus.res_valid), 1);
    nxt();
    smp();
    chk("bp_no_dup", 32'(bus.res_valid), 0);
    nxt();

    // Reset with two ops in flight (pointer is at 2 here)
    bus.req_x[2] = 8'd3; bus.req_y[2] = 8'd5;
    bus.req_x[3] = 8'd7; bus.req_y[3] = 8'd9;
    bus.approx_en = 1'b0;
    bus.req_valid = 4'b1100;
    smp();
    chk("rstf_gnt2", 32'(bus.req_ready), 32'h4);
    nxt();
    smp();
    chk("rstf_gnt3", 32'(bus.req_ready), 32'h8);
    nxt();
    rst = 1'b1;
    bus.req_valid = '0;
    smp();
    chk("rstf_inflight_z", 32'(bus.res_z), 15);
    nxt();
    rst = 1'b0;
    smp();
    chk("rstf_vld", 32'(bus.res_valid), 0);
    chk("rstf_rr_ptr", 32'(dut.rr_ptr), 0);
    chk("rstf_s1", 32'(dut.s1_valid), 0);
    nxt();
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("rstf_no_stale", 32'(bus.res_valid), 0);
      nxt();
    end

    // Random traffic against the golden model, per-id in order
    acc = '0;
    for (int cyc = 0; cyc < 14000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !acc[i]) begin
          if ($urandom_range(0, 7) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) != 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_x[i] = 8'($urandom);
          bus.req_y[i] = 8'($urandom);
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.approx_en = 1'($urandom_range(0, 1));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      smp();
      acc = bus.req_valid & bus.req_ready;
      chk("rnd_onehot", 32'($onehot0(bus.req_ready)), 1);
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) begin
          expq[i].push_back({bus.approx_en, gold(bus.req_x[i], bus.req_y[i], bus.approx_en)});
          n_acc++;
        end
      handle_res();
      nxt();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      smp();
      handle_res();
      nxt();
    end
    chk("rnd_count", 32'(n_res), 32'(n_acc));
    chk("rnd_left", 32'(expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
